// File: rtl/bcd_7seg_scan_driver.sv
// rtl/bcd_7seg_scan_driver.sv - multiplexed BCD to 7-segment scan driver with frame-synchronous update
//
// Purpose: scans NUM_DIGITS BCD digits onto a shared 7-segment bus. A prescaler
// sets the time each digit is lit. New values are staged in a pending register
// and only copied to the displayed register at the end of a full scan frame,
// so a frame never shows a mix of old and new digits.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - asynchronous active-high reset
//   load       - capture bcd_in into the pending register
//   bcd_in     - packed BCD digits, digit k in [4k+3:4k], digit 0 least significant
//   blank_lz   - suppress leading zeros (digit 0 is always shown)
//   seg        - registered segments {a,b,c,d,e,f,g}, polarity set by SEG_ACTIVE_LOW
//   an         - registered one-hot digit enable, polarity set by AN_ACTIVE_LOW
//   pending    - a loaded value is waiting for the next frame boundary
//   frame_done - one-cycle pulse after each completed scan frame

module bcd_7seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int                    IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int                    CNT_W    = 16;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pending_q, pending_d;
  logic                    frame_done_q, frame_done_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    tick;
  logic                    wrap;
  logic [3:0]              cur_digit;
  logic                    cur_lz;
  logic                    zero_run;
  logic                    blank;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   an_raw;

  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;  // non-BCD codes show a dash
    endcase
    return s;
  endfunction

  assign tick = (cnt_q == CNT_LAST);
  // The last digit slot ending closes the frame; with one digit every tick does.
  assign wrap = tick && (idx_q == IDX_LAST);

  // Prescaler and digit index
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (tick) begin
      cnt_d = '0;
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Staging: the displayed value only changes on a wrap tick. A load on the
  // wrap tick still promotes the previously pending value, and the new value
  // stays pending for the following frame.
  always_comb begin
    disp_d       = disp_q;
    pend_d       = pend_q;
    pending_d    = pending_q;
    frame_done_d = wrap;
    if (wrap && pending_q) begin
      disp_d = pend_q;
    end
    if (load) begin
      pend_d    = bcd_in;
      pending_d = 1'b1;
    end else if (wrap && pending_q) begin
      pending_d = 1'b0;
    end
  end

  // Digit select and leading-zero detect. zero_run walks down from the most
  // significant digit and stays high while every digit seen so far is zero.
  always_comb begin
    cur_digit = 4'd0;
    cur_lz    = 1'b0;
    zero_run  = 1'b1;
    an_raw    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (disp_q[4*k +: 4] == 4'd0);
      if (idx_q == IDX_W'(k)) begin
        cur_digit = disp_q[4*k +: 4];
        cur_lz    = zero_run;
        an_raw[k] = 1'b1;
      end
    end
    blank   = blank_lz && (idx_q != '0) && cur_lz;
    seg_raw = blank ? 7'b0000000 : decode_digit(cur_digit);
    seg_d   = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    an_d    = AN_ACTIVE_LOW ? ~an_raw : an_raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// tb/tb_bcd_7seg_scan_driver.sv - self-checking bench for bcd_7seg_scan_driver
module tb_bcd_7seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];

  always #5 clk = ~clk;

  bcd_7seg_scan_driver #(
    .NUM_DIGITS    (4),
    .REFRESH_DIV   (4),
    .SEG_ACTIVE_LOW(1'b0),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .bcd_in    (bcd_in),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .an        (an),
    .pending   (pending),
    .frame_done(frame_done)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  // Expected {seg, an} for the four slots of one frame showing value v.
  function automatic void push_frame(input logic [15:0] v, input logic blz);
    int         hi;
    logic [6:0] s;
    logic [3:0] a;
    hi = -1;
    for (int k = 0; k < 4; k++)
      if (v[4*k +: 4] != 4'h0) hi = k;
    for (int k = 0; k < 4; k++) begin
      if (blz && k > 0 && k > hi) s = 7'b0000000;
      else                        s = ref_seg(v[4*k +: 4]);
      a    = 4'b1111;
      a[k] = 1'b0;
      exp_q.push_back({s, a});
    end
  endfunction

  task automatic wait_frame_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) got = 1'b1;
    end
  endtask

  // Records one frame of outputs; the first sample is the slot showing digit 0.
  task automatic sample_frame();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) @(negedge clk);
      else repeat (4) @(negedge clk);
      obs_q.push_back({seg, an});
    end
  endtask

  task automatic test_reset();
    logic [10:0] e, o;
    int          pulses;
    rst = 1'b1; load = 1'b0; bcd_in = 16'h0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (seg !== 7'b0000000) begin failures++; $display("FAIL reset_seg got=%b exp=%b", seg, 7'b0000000); end
    checks++; if (an !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b exp=%b", an, 4'b1111); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pending); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    push_frame(16'h0000, 1'b0);
    rst = 1'b0;
    sample_frame();
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_scan digit%0d got seg=%b an=%b exp seg=%b an=%b", k, o[10:4], o[3:0], e[10:4], e[3:0]); end
    end
    pulses = 0;
    repeat (32) begin @(negedge clk); if (frame_done === 1'b1) pulses++; end
    checks++; if (pulses != 2) begin failures++; $display("FAIL frame_done_rate got=%0d exp=2 per 32 clocks", pulses); end
  endtask

  task automatic test_load_midframe();
    logic [10:0] e, o;
    bit          got;
    wait_frame_done(got);
    if (!got) begin checks++; failures++; $display("FAIL midframe_sync got=timeout exp=frame_done"); return; end
    load = 1'b1; bcd_in = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL midframe_pending got=%b exp=1", pending); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL frame_done_width got=%b exp=0", frame_done); end
    checks++; if ({seg, an} !== {7'b1111110, 4'b1110}) begin failures++; $display("FAIL midframe_hold0 got seg=%b an=%b exp seg=1111110 an=1110", seg, an); end
    repeat (8) @(negedge clk);
    checks++; if ({seg, an} !== {7'b1111110, 4'b1011}) begin failures++; $display("FAIL midframe_hold2 got seg=%b an=%b exp seg=1111110 an=1011", seg, an); end
    push_frame(16'h1234, 1'b0);
    wait_frame_done(got);
    if (!got) begin checks++; failures++; exp_q.delete(); $display("FAIL midframe_wrap got=timeout exp=frame_done"); return; end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL midframe_pending_clear got=%b exp=0", pending); end
    sample_frame();
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL midframe_1234 digit%0d got seg=%b an=%b exp seg=%b an=%b", k, o[10:4], o[3:0], e[10:4], e[3:0]); end
    end
  endtask

  task automatic test_blank_lz();
    logic [10:0] e, o;
    bit          got;
    wait_frame_done(got);
    if (!got) begin checks++; failures++; $display("FAIL blank_sync got=timeout exp=frame_done"); return; end
    load = 1'b1; bcd_in = 16'h0007; blank_lz = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push_frame(16'h0007, 1'b1);
    wait_frame_done(got);
    if (!got) begin checks++; failures++; exp_q.delete(); $display("FAIL blank_wrap got=timeout exp=frame_done"); return; end
    sample_frame();
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL blank_on digit%0d got seg=%b an=%b exp seg=%b an=%b", k, o[10:4], o[3:0], e[10:4], e[3:0]); end
    end
    blank_lz = 1'b0;
    push_frame(16'h0007, 1'b0);
    wait_frame_done(got);
    if (!got) begin checks++; failures++; exp_q.delete(); $display("FAIL noblank_wrap got=timeout exp=frame_done"); return; end
    sample_frame();
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL blank_off digit%0d got seg=%b an=%b exp seg=%b an=%b", k, o[10:4], o[3:0], e[10:4], e[3:0]); end
    end
  endtask

  task automatic test_dash();
    logic [10:0] e, o;
    bit          got;
    blank_lz = 1'b1;
    wait_frame_done(got);
    if (!got) begin checks++; failures++; $display("FAIL dash_sync got=timeout exp=frame_done"); return; end
    load = 1'b1; bcd_in = 16'hA0F5;
    @(negedge clk);
    load = 1'b0;
    push_frame(16'hA0F5, 1'b1);
    wait_frame_done(got);
    if (!got) begin checks++; failures++; exp_q.delete(); $display("FAIL dash_wrap got=timeout exp=frame_done"); return; end
    sample_frame();
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL dash_a0f5 digit%0d got seg=%b an=%b exp seg=%b an=%b", k, o[10:4], o[3:0], e[10:4], e[3:0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e, o;
    bit          got;
    blank_lz = 1'b0;
    wait_frame_done(got);
    if (!got) begin checks++; failures++; $display("FAIL b2b_sync got=timeout exp=frame_done"); return; end
    load = 1'b1; bcd_in = 16'h1111;
    @(negedge clk);
    bcd_in = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    repeat (13) @(negedge clk);
    // next edge is the wrap tick
    load = 1'b1; bcd_in = 16'h3333;
    @(negedge clk);
    load = 1'b0;
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL b2b_wrap_align got=%b exp=1", frame_done); end
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL b2b_pending got=%b exp=1", pending); end
    push_frame(16'h2222, 1'b0);
    sample_frame();
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL b2b_2222 digit%0d got seg=%b an=%b exp seg=%b an=%b", k, o[10:4], o[3:0], e[10:4], e[3:0]); end
    end
    push_frame(16'h3333, 1'b0);
    wait_frame_done(got);
    if (!got) begin checks++; failures++; exp_q.delete(); $display("FAIL b2b_wrap2 got=timeout exp=frame_done"); return; end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL b2b_pending_clear got=%b exp=0", pending); end
    sample_frame();
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL b2b_3333 digit%0d got seg=%b an=%b exp seg=%b an=%b", k, o[10:4], o[3:0], e[10:4], e[3:0]); end
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] e, o;
    bit          got;
    wait_frame_done(got);
    if (!got) begin checks++; failures++; $display("FAIL areset_sync got=timeout exp=frame_done"); return; end
    load = 1'b1; bcd_in = 16'h5678;
    @(negedge clk);
    load = 1'b0;
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL areset_pre_pending got=%b exp=1", pending); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (seg !== 7'b0000000) begin failures++; $display("FAIL areset_seg got=%b exp=0000000", seg); end
    checks++; if (an !== 4'b1111) begin failures++; $display("FAIL areset_an got=%b exp=1111", an); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL areset_pending got=%b exp=0", pending); end
    @(negedge clk);
    rst = 1'b0;
    push_frame(16'h0000, 1'b0);
    sample_frame();
    push_frame(16'h0000, 1'b0);
    wait_frame_done(got);
    if (!got) begin checks++; failures++; exp_q.delete(); obs_q.delete(); $display("FAIL areset_wrap got=timeout exp=frame_done"); return; end
    sample_frame();
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL areset_scan slot%0d got seg=%b an=%b exp seg=%b an=%b", k, o[10:4], o[3:0], e[10:4], e[3:0]); end
    end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL areset_pending_after got=%b exp=0", pending); end
  endtask

  initial begin
    test_reset();
    test_load_midframe();
    test_blank_lz();
    test_dash();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_7seg_scan_driver.md
BCD_7SEG_SCAN_DRIVER -- requirements
Module: bcd_7seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clocks per digit slot, legal range 2..65535.
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 0; when 1, seg is driven inverted (0 = segment on).
REQ-004 SHALL have parameter AN_ACTIVE_LOW, default 1; when 1, an is driven inverted (0 = digit on).
REQ-005 SHALL have port clk, input, 1 bit; the single clock, all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-007 SHALL have port load, input, 1 bit; captures bcd_in on a rising clk edge while high.
REQ-008 SHALL have port bcd_in, input, 4*NUM_DIGITS bits; digit k in bits [4k+3:4k], digit 0 least significant.
REQ-009 SHALL have port blank_lz, input, 1 bit; enables leading-zero suppression.
REQ-010 SHALL have port seg, output, 7 bits; segments {a,b,c,d,e,f,g}, a = bit 6, registered.
REQ-011 SHALL have port an, output, NUM_DIGITS bits; digit enables, one-hot when active, registered.
REQ-012 SHALL have port pending, output, 1 bit; high while a loaded value awaits the frame boundary.
REQ-013 SHALL have port frame_done, output, 1 bit; one-cycle pulse per completed scan frame.

Function
REQ-014 SHALL run prescaler cnt 0..REFRESH_DIV-1, wrapping to 0; tick = (cnt == REFRESH_DIV-1).
REQ-015 SHALL advance digit index idx by 1 on each tick, wrapping NUM_DIGITS-1 -> 0 (wrap tick); with NUM_DIGITS=1, idx stays 0 and every tick is a wrap tick.
REQ-016 SHALL, on load, write bcd_in into pend_reg and set pending next cycle; repeated load while pending overwrites pend_reg (last write wins).
REQ-017 SHALL, on a wrap tick with pending=1 and load=0, copy pend_reg to disp_reg and clear pending in the same edge.
REQ-018 SHALL, on load coincident with a wrap tick, copy the old pend_reg to disp_reg only if pending was 1, capture the new bcd_in into pend_reg, and leave pending=1.
REQ-019 SHALL never change disp_reg except at a wrap tick (no mid-frame tearing).
REQ-020 SHALL drive seg/an each cycle from the current idx and disp_reg, registered: one-clock latency from idx change.
REQ-021 SHALL decode active-high, before polarity: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-022 SHALL decode codes 10..15 as dash 0000001.
REQ-023 SHALL, with blank_lz=1, blank (seg all off) digit k>0 when digit k and all higher digits of disp_reg are 0; digit 0 is never blanked.
REQ-024 SHALL keep an one-hot on bit idx (polarity applied) at all times out of reset; a blanked digit still has its an bit active.
REQ-025 SHALL pulse frame_done high exactly one cycle, on the cycle after each wrap tick.
REQ-026 SHALL sample blank_lz combinationally into the registered output path (takes effect next edge).

Reset
REQ-027 SHALL, while rst=1, asynchronously force cnt=0, idx=0, disp_reg=0, pend_reg=0, pending=0, frame_done=0.
REQ-028 SHALL, while rst=1, drive seg all-off and an all-off (polarity applied: all 1s when active-low).
REQ-029 SHALL, on the first edge after rst falls, drive an for digit 0 with seg = "0" pattern.
REQ-030 SHALL, on reset mid-frame or with pending=1, discard pend_reg and restart the frame from digit 0.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=1)
REQ-031 SHALL check: reset release, no load -> seg=1111110, an=1110 then 1101, 1011, 0111 every 4 clocks; frame_done once per 16 clocks.
REQ-032 SHALL check: load bcd_in=16'h1234 mid-frame -> pending=1, display unchanged until wrap tick, then digit 0 shows 0110011 ("4"), digit 3 shows 0110000 ("1"), pending=0.
REQ-033 SHALL check: disp=16'h0007, blank_lz=1 -> digits 3..1 seg=0000000, digit 0 seg=1110000; blank_lz=0 -> digits 3..1 show 1111110.
REQ-034 SHALL check: bcd_in=16'hA0F5 loaded -> digits 3 and 1 show 0000001, digit 2 shows 1111110, digit 0 shows 1011011.
REQ-035 SHALL check: load 16'h1111 then 16'h2222 before the wrap tick, and load 16'h3333 on the wrap tick -> disp=16'h2222, pend=16'h3333, pending=1.
REQ-036 SHALL check: rst asserted asynchronously mid-clock with pending=1 -> seg=0000000 and an=1111 immediately, and pending=0.
